line_buffer3: RTL
=================

LINE_BUFFER3 -- requirements
Module: line_buffer3

Interface
REQ-001 SHALL have parameter PIXEL_WIDTH, default 8, bits per pixel.
REQ-002 SHALL have parameter IMG_WIDTH, default 64, pixels per line (min 3).
REQ-003 SHALL have parameter IMG_HEIGHT, default 64, lines per frame (min 3).
REQ-004 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port pix_in  input  PIXEL_WIDTH  raster-order pixel; bits passed unmodified.
REQ-007 SHALL have port pix_valid  input  1  pix_in is valid this cycle; no backpressure.
REQ-008 SHALL have port sof  input  1  start of frame; qualifies the pixel presented with it.
REQ-009 SHALL have port pix_top  output  PIXEL_WIDTH  pixel at (row-2, col).
REQ-010 SHALL have port pix_mid  output  PIXEL_WIDTH  pixel at (row-1, col).
REQ-011 SHALL have port pix_bot  output  PIXEL_WIDTH  pixel at (row, col).
REQ-012 SHALL have port out_valid  output  1  top/mid/bot column valid.
REQ-013 SHALL have port col_first  output  1  out column is col 0 (convolver window restart).
REQ-014 SHALL have port col_last  output  1  out column is col IMG_WIDTH-1.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse with last column of last row.

Function
REQ-016 SHALL hold two line memories, line0 (row-1) and line1 (row-2), IMG_WIDTH entries each.
REQ-017 SHALL keep col counter (0..IMG_WIDTH-1) and row counter (0..IMG_HEIGHT-1), advanced only on accepted pixels (pix_valid=1).
REQ-018 On accepted pixel at col c: SHALL register pix_top<=line1[c], pix_mid<=line0[c], pix_bot<=pix_in, then write line1[c]<=line0[c], line0[c]<=pix_in (read-before-write same cycle).
REQ-019 Latency SHALL be exactly 1 cycle: accepted pixel at edge N appears on outputs after edge N.
REQ-020 out_valid SHALL be 1 in the cycle after an accepted pixel with row>=2, else 0; outputs hold last value when out_valid=0.
REQ-021 Rows 0 and 1 SHALL fill memories only (out_valid=0).
REQ-022 col SHALL wrap IMG_WIDTH-1 -> 0 and increment row; at row IMG_HEIGHT-1, col IMG_WIDTH-1 SHALL wrap row to 0 and pulse frame_done with that output column.
REQ-023 col_first/col_last SHALL be registered alongside data, valid only when out_valid=1.
REQ-024 sof with pix_valid SHALL force that pixel to col 0, row 0 regardless of counters (mid-frame restart); memory contents need not be cleared since rows 0/1 overwrite before use.
REQ-025 sof without pix_valid SHALL be ignored.
REQ-026 Gaps (pix_valid=0) of any length SHALL not alter counters or memories.
REQ-027 Pixel bits SHALL pass unmodified (no sign/width conversion).

Reset
REQ-028 rst_n=0 SHALL asynchronously clear col, row, pix_top, pix_mid, pix_bot, out_valid, col_first, col_last, frame_done to 0; line memories need not reset.
REQ-029 First accepted pixel after reset release SHALL be row 0, col 0, with or without sof.

Verification (IMG_WIDTH=4, IMG_HEIGHT=4, pixel=16*row+col)
REQ-030 Stream rows 0-1 continuously -> out_valid stays 0 for all 8 pixels.
REQ-031 Pixel (2,1)=0x21 accepted -> next cycle top=0x01, mid=0x11, bot=0x21, out_valid=1, col_first=0, col_last=0.
REQ-032 Pixel (3,3)=0x33 accepted -> next cycle top=0x13, mid=0x23, bot=0x33, col_last=1, frame_done=1 for one cycle; next pixel treated as (0,0).
REQ-033 Random pix_valid gaps (50% duty) over full frame -> output sequence identical to gapless run, no extra out_valid pulses.
REQ-034 sof asserted at pixel (2,2) -> counters restart, out_valid=0 until two new rows received, then windows use new-frame data only.
REQ-035 rst_n pulsed low mid-row 3 -> all outputs 0 immediately (asynchronous), following pixel treated as (0,0), out_valid=0 for next 8 pixels.

Source files
------------

// File: rtl/line_buffer3.sv
// Three-row line buffer for a 3x3 convolver.
// Streams raster pixels in and emits one vertical column (row-2, row-1, row) per accepted pixel.
module line_buffer3 #(
  parameter int unsigned PIXEL_WIDTH = 8,
  parameter int unsigned IMG_WIDTH   = 64,
  parameter int unsigned IMG_HEIGHT  = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [PIXEL_WIDTH-1:0] pix_in,
  input  logic                   pix_valid,
  input  logic                   sof,
  output logic [PIXEL_WIDTH-1:0] pix_top,
  output logic [PIXEL_WIDTH-1:0] pix_mid,
  output logic [PIXEL_WIDTH-1:0] pix_bot,
  output logic                   out_valid,
  output logic                   col_first,
  output logic                   col_last,
  output logic                   frame_done
);

  localparam int unsigned CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int unsigned RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] ColMax = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] RowMax = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] RowTwo = RW'(2);

  logic [PIXEL_WIDTH-1:0] line0 [IMG_WIDTH];
  logic [PIXEL_WIDTH-1:0] line1 [IMG_WIDTH];

  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic          at_col_last;
  logic          at_row_last;

  // sof relocates the qualifying pixel to the frame origin before it is used anywhere.
  always_comb begin
    cur_col     = sof ? '0 : col_q;
    cur_row     = sof ? '0 : row_q;
    at_col_last = (cur_col == ColMax);
    at_row_last = (cur_row == RowMax);
    col_d       = col_q;
    row_d       = row_q;
    if (pix_valid) begin
      if (at_col_last) begin
        col_d = '0;
        row_d = at_row_last ? '0 : cur_row + RW'(1);
      end else begin
        col_d = cur_col + CW'(1);
        row_d = cur_row;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      pix_top    <= '0;
      pix_mid    <= '0;
      pix_bot    <= '0;
      out_valid  <= 1'b0;
      col_first  <= 1'b0;
      col_last   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (pix_valid) begin
        pix_top    <= line1[cur_col];
        pix_mid    <= line0[cur_col];
        pix_bot    <= pix_in;
        out_valid  <= (cur_row >= RowTwo);
        col_first  <= (cur_row >= RowTwo) && (cur_col == '0);
        col_last   <= (cur_row >= RowTwo) && at_col_last;
        frame_done <= at_row_last && at_col_last;
      end else begin
        out_valid  <= 1'b0;
        col_first  <= 1'b0;
        col_last   <= 1'b0;
        frame_done <= 1'b0;
      end
    end
  end

  // Line memories are not reset; rows 0 and 1 of every frame refill them before use.
  always_ff @(posedge clk) begin
    if (pix_valid) begin
      line1[cur_col] <= line0[cur_col];
      line0[cur_col] <= pix_in;
    end
  end

endmodule
